drop_timing_ctrl: RTL and testbench

Upstream stage of the seven-segment display/drop decision logic. Produces the t_act, t_lim and drop_en inputs that the display/drop block consumes.
- Accepts NUM_SENSORS height samples over a valid/ready handshake.
- Averages the non-zero samples with a sequential restoring divider.
- Computes t_act = isqrt(avg << SCALE_SHIFT) with a sequential bit-by-bit square root.
- Latches t_lim and keeps the drop_en cockpit latch.

---
 rtl/drop_pkg.sv | 18 +
 rtl/seq_isqrt.sv | 60 ++++++
 rtl/drop_timing_ctrl.sv | 137 +++++++++++++
 tb/tb_drop_timing_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/drop_pkg.sv
// Shared types and default sizing for the drop timing path.
// Latency constants are derived from the default widths.
package drop_pkg;

    localparam int SAMPLE_W    = 8;
    localparam int T_W         = 16;
    localparam int SCALE_SHIFT = 8;
    localparam int DIV_CYCLES  = SAMPLE_W + 2;
    localparam int SQRT_CYCLES = (SAMPLE_W + SCALE_SHIFT) / 2;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DIV     = 2'd1,
        SQRT    = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/seq_isqrt.sv
// Bit-by-bit floor square root, ITER fixed iterations, first one on the start edge.
// done is high during the cycle in which the last iteration executes.
module seq_isqrt #(
    parameter int RAD_W = 16,
    parameter int ROOT_W = 8,
    parameter int ITER = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RAD_W-1:0]  radicand,
    output logic              busy,
    output logic              done,
    output logic [ROOT_W-1:0] root
);

    localparam int REM_W = ROOT_W + 3;
    localparam int CNT_W = $clog2(ITER + 1);

    logic [RAD_W-1:0]  rad, cur_rad, rad_nx;
    logic [REM_W-1:0]  rem, cur_rem, rem_nx, acc, trial;
    logic [ROOT_W-1:0] root_r, cur_root, root_nx;
    logic [CNT_W-1:0]  cnt;

    // The start cycle works straight from the radicand input so no load cycle is spent.
    always_comb begin
        cur_rad  = start ? radicand : rad;
        cur_rem  = start ? '0 : rem;
        cur_root = start ? '0 : root_r;
        acc      = {cur_rem[REM_W-3:0], cur_rad[2*ITER-1 -: 2]};
        trial    = REM_W'({cur_root, 2'b01});
        rad_nx   = cur_rad << 2;
        if (acc >= trial) begin
            rem_nx  = acc - trial;
            root_nx = {cur_root[ROOT_W-2:0], 1'b1};
        end else begin
            rem_nx  = acc;
            root_nx = {cur_root[ROOT_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rad    <= '0;
            rem    <= '0;
            root_r <= '0;
            cnt    <= '0;
        end else if (start || busy) begin
            rad    <= rad_nx;
            rem    <= rem_nx;
            root_r <= root_nx;
            cnt    <= start ? CNT_W'(ITER - 1) : cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);
    assign done = (cnt == CNT_W'(1));
    assign root = root_r;

endmodule

// File: rtl/drop_timing_ctrl.sv
// Collects NUM_SENSORS samples, averages non-zero ones, roots the scaled average into t_act.
// Result 19 edges after the last accepted sample; sample_ready drops while computing.
module drop_timing_ctrl #(
    parameter int SAMPLE_W    = drop_pkg::SAMPLE_W,
    parameter int NUM_SENSORS = 4,
    parameter int SCALE_SHIFT = drop_pkg::SCALE_SHIFT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic [SAMPLE_W-1:0] sample_data,
    input  logic [15:0]         t_lim_in,
    input  logic                cockpit_close,
    input  logic                cockpit_open,
    output logic [15:0]         t_act,
    output logic [15:0]         t_lim,
    output logic                drop_en,
    output logic                result_valid,
    output logic                busy
);

    import drop_pkg::*;

    localparam int SUM_W  = SAMPLE_W + 2;
    localparam int DIV_N  = SAMPLE_W + 2;
    localparam int SQ_N   = (SAMPLE_W + SCALE_SHIFT) / 2;
    localparam int STEP_W = $clog2(DIV_N);

    state_t            state;
    logic [2:0]        idx;
    logic [2:0]        cnt_nz;
    logic [SUM_W-1:0]  sum;
    logic [2:0]        rem;
    logic [STEP_W-1:0] step;

    logic [3:0]          r2;
    logic                q_bit;
    logic [2:0]          rem_next;
    logic [SAMPLE_W-1:0] avg;
    logic [T_W-1:0]      radicand;
    logic                sq_start, sq_busy, sq_done;
    logic [7:0]          root;

    // Restoring division: sum doubles as the dividend/quotient shift register.
    always_comb begin
        r2       = {rem, sum[SUM_W-1]};
        q_bit    = (r2 >= {1'b0, cnt_nz});
        rem_next = q_bit ? 3'(r2 - {1'b0, cnt_nz}) : r2[2:0];
    end

    assign avg      = (cnt_nz == 3'd0) ? '0 : sum[SAMPLE_W-1:0];
    assign radicand = T_W'({avg, {SCALE_SHIFT{1'b0}}});
    assign sq_start = (state == SQRT) && !sq_busy;

    seq_isqrt #(
        .RAD_W (T_W),
        .ROOT_W(8),
        .ITER  (SQ_N)
    ) u_isqrt (
        .clk     (clk),
        .rst     (rst),
        .start   (sq_start),
        .radicand(radicand),
        .busy    (sq_busy),
        .done    (sq_done),
        .root    (root)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= COLLECT;
            idx          <= '0;
            cnt_nz       <= '0;
            sum          <= '0;
            rem          <= '0;
            step         <= '0;
            t_act        <= '0;
            t_lim        <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                COLLECT: begin
                    if (sample_valid) begin
                        if (sample_data != '0) begin
                            sum    <= sum + SUM_W'(sample_data);
                            cnt_nz <= cnt_nz + 3'd1;
                        end
                        idx <= idx + 3'd1;
                        if (idx == 3'(NUM_SENSORS - 1)) begin
                            state <= DIV;
                            step  <= '0;
                            rem   <= '0;
                        end
                    end
                end
                DIV: begin
                    sum  <= {sum[SUM_W-2:0], q_bit};
                    rem  <= rem_next;
                    step <= step + STEP_W'(1);
                    if (step == STEP_W'(DIV_N - 1))
                        state <= SQRT;
                end
                SQRT: begin
                    if (sq_done)
                        state <= DONE;
                end
                DONE: begin
                    t_act        <= T_W'(root);
                    t_lim        <= t_lim_in;
                    result_valid <= 1'b1;
                    sum          <= '0;
                    idx          <= '0;
                    cnt_nz       <= '0;
                    rem          <= '0;
                    state        <= COLLECT;
                end
                default: state <= COLLECT;
            endcase
        end
    end

    // Open takes priority so a conflicting pair of pulses lands in the safe state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_en <= 1'b0;
        else if (cockpit_open)
            drop_en <= 1'b0;
        else if (cockpit_close)
            drop_en <= 1'b1;
    end

    assign sample_ready = (state == COLLECT);
    assign busy         = (state != COLLECT);

endmodule

// File: tb/tb_drop_timing_ctrl.sv
// Randomized and directed bench for drop_timing_ctrl against a measurement-level model.
module tb_drop_timing_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [7:0]  sample_data = '0;
    logic [15:0] t_lim_in = '0;
    logic        cockpit_close = 1'b0;
    logic        cockpit_open = 1'b0;
    logic [15:0] t_act;
    logic [15:0] t_lim;
    logic        drop_en;
    logic        result_valid;
    logic        busy;

    drop_timing_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .t_lim_in     (t_lim_in),
        .cockpit_close(cockpit_close),
        .cockpit_open (cockpit_open),
        .t_act        (t_act),
        .t_lim        (t_lim),
        .drop_en      (drop_en),
        .result_valid (result_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: accepted samples, when the result is due, when input reopens.
    int          edge_n    = 0;
    int          due       = -1;
    int          next_free = 0;
    logic [7:0]  acc_q[$];
    logic [15:0] pend_tact, pend_tlim;
    logic [15:0] exp_tact = '0, exp_tlim = '0;
    logic        exp_drop = 1'b0;
    logic        exp_ready;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d at edge %0d", tag, got, exp, edge_n);
        end
    endtask

    function automatic int isqrt_ref(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    task automatic model_reset();
        acc_q.delete();
        due       = -1;
        next_free = 0;
        exp_tact  = '0;
        exp_tlim  = '0;
        exp_drop  = 1'b0;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic cc,
                        input logic co, input logic [15:0] tl);
        int s, n, avg;
        sample_valid  = v;
        sample_data   = d;
        cockpit_close = cc;
        cockpit_open  = co;
        t_lim_in      = tl;
        exp_ready = (edge_n + 1 >= next_free);
        chk("sample_ready", sample_ready, exp_ready);
        chk("busy", busy, !exp_ready);
        if (v && exp_ready) begin
            acc_q.push_back(d);
            if (acc_q.size() == 4) begin
                s = 0;
                n = 0;
                foreach (acc_q[i]) if (acc_q[i] != 0) begin s += acc_q[i]; n++; end
                avg       = (n == 0) ? 0 : s / n;
                pend_tact = 16'(isqrt_ref(avg * 256));
                due       = edge_n + 1 + 19;
                next_free = edge_n + 1 + 20;
                acc_q.delete();
            end
        end
        if (edge_n + 1 == due) pend_tlim = tl;
        if (co) exp_drop = 1'b0;
        else if (cc) exp_drop = 1'b1;
        @(posedge clk);
        edge_n++;
        #1;
        if (edge_n == due) begin
            exp_tact = pend_tact;
            exp_tlim = pend_tlim;
        end
        chk("result_valid", result_valid, edge_n == due);
        chk("t_act", t_act, exp_tact);
        chk("t_lim", t_lim, exp_tlim);
        chk("drop_en", drop_en, exp_drop);
    endtask

    // Feeds four samples (junk held valid while busy), then `tail` busy cycles.
    task automatic measure(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input bit gaps, input int tail);
        logic [7:0] s[4];
        int guard;
        s = '{a, b, c, d};
        for (int i = 0; i < 4; i++) begin
            guard = 0;
            while (!(edge_n + 1 >= next_free) && guard < 100) begin
                step(1'b1, 8'($urandom), 1'b0, 1'b0, 16'd200);
                guard++;
            end
            if (gaps) step(1'b0, 8'd77, 1'b0, 1'b0, 16'd200);
            step(1'b1, s[i], 1'b0, 1'b0, 16'd200);
        end
        for (int j = 0; j < tail; j++) step(1'b1, 8'($urandom), 1'b0, 1'b0, 16'd200);
    endtask

    initial begin
        repeat (3) begin @(posedge clk); edge_n++; end
        #1;
        chk("rst_t_act", t_act, 0);
        chk("rst_t_lim", t_lim, 0);
        chk("rst_drop_en", drop_en, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_sample_ready", sample_ready, 1);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        model_reset();

        measure(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 19);
        chk("avg100_rv_k19", result_valid, 1);
        chk("avg100_t_act", t_act, 160);
        chk("avg100_t_lim", t_lim, 200);
        measure(8'd90, 8'd0, 8'd90, 8'd90, 1'b1, 19);
        chk("avg90_t_act", t_act, 151);
        measure(8'd2, 8'd1, 8'd0, 8'd0, 1'b0, 19);
        chk("avg1_t_act", t_act, 16);
        measure(8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 19);
        chk("zero_rv_k19", result_valid, 1);
        chk("zero_t_act", t_act, 0);
        measure(8'd255, 8'd255, 8'd255, 8'd255, 1'b1, 19);
        chk("max_t_act", t_act, 255);

        step(1'b0, 8'd0, 1'b1, 1'b0, 16'd200);
        chk("close_sets", drop_en, 1);
        step(1'b0, 8'd0, 1'b1, 1'b1, 16'd200);
        chk("both_open_wins", drop_en, 0);
        step(1'b0, 8'd0, 1'b1, 1'b0, 16'd200);
        step(1'b0, 8'd0, 1'b0, 1'b1, 16'd200);
        chk("open_clears", drop_en, 0);

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
                 16'($urandom));
        end

        // Abort a computation partway through the square root.
        step(1'b0, 8'd0, 1'b1, 1'b0, 16'd200);
        measure(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 0);
        while (!(edge_n + 1 >= next_free)) step(1'b0, 8'd0, 1'b0, 1'b0, 16'd200);
        step(1'b0, 8'd0, 1'b1, 1'b0, 16'd200);
        measure(8'd100, 8'd100, 8'd100, 8'd100, 1'b0, 13);
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_drop_en", drop_en, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_t_act", t_act, 0);
        chk("midrst_t_lim", t_lim, 0);
        chk("midrst_drop_en", drop_en, 0);
        chk("midrst_result_valid", result_valid, 0);
        chk("midrst_sample_ready", sample_ready, 1);
        chk("midrst_busy", busy, 0);
        @(posedge clk); edge_n++;
        @(posedge clk); edge_n++;
        #1;
        rst = 1'b0;
        model_reset();
        measure(8'd64, 8'd64, 8'd64, 8'd64, 1'b0, 19);
        chk("post_rst_t_act", t_act, 128);
        chk("post_rst_rv", result_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
